// File: rtl/rip_trap_unit.sv
// Machine-mode CSR file (MTVEC, MEPC, MCAUSE) and trap/MRET redirect sequencer for rip-cpu.
// Optional MSCRATCH at 0x340 is enabled by defining RIP_MSCRATCH_EN.
`timescale 1ns/1ps

module rip_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter int unsigned CAUSE_W     = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    input  logic               trap_valid,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic [31:0]        trap_pc,
    input  logic               mret_valid,
    output logic               busy,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc
);

    typedef enum logic [1:0] {StIdle, StTrapSave, StTrapJump, StMretJump} state_e;

    localparam logic [11:0] AddrMscratch = 12'h340;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;

    state_e              state_q;
    logic [31:0]         mtvec_q;
    logic [31:0]         mepc_q;
    logic [CAUSE_W-1:0]  mcause_q;
    logic                busy_q;
    logic                redirect_valid_q;
    logic [31:0]         redirect_pc_q;
`ifdef RIP_MSCRATCH_EN
    logic [31:0]         mscratch_q;
`endif

    logic [31:0]         csr_old;
    logic [31:0]         csr_new;
    logic                csr_hit;
    logic                csr_we;
    logic [31:0]         mcause_ext;
    logic [CAUSE_W-1:0]  cause_new;
    logic                unused_trap_pc;

    assign mcause_ext     = 32'(mcause_q);
    assign cause_new      = CAUSE_W'(csr_new);
    assign unused_trap_pc = ^trap_pc[1:0];

    always_comb begin
        csr_hit = 1'b1;
        csr_old = '0;
        case (csr_addr)
            AddrMtvec:    csr_old = mtvec_q;
            AddrMepc:     csr_old = mepc_q;
            AddrMcause:   csr_old = mcause_ext;
`ifdef RIP_MSCRATCH_EN
            AddrMscratch: csr_old = mscratch_q;
`endif
            default:      csr_hit = 1'b0;
        endcase
    end

    always_comb begin
        csr_new = csr_old;
        case (csr_op)
            2'b01:   csr_new = csr_wdata;
            2'b10:   csr_new = csr_old | csr_wdata;
            2'b11:   csr_new = csr_old & ~csr_wdata;
            default: csr_new = csr_old;
        endcase
    end

    assign csr_rdata   = (csr_op != 2'b00 && csr_hit) ? csr_old : 32'h0;
    assign csr_illegal = (csr_op != 2'b00) && !csr_hit;

    // Lower-priority requests lose to trap/mret and are dropped, never queued.
    assign csr_we = (state_q == StIdle) && !trap_valid && !mret_valid &&
                    (csr_op != 2'b00) && csr_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= StIdle;
            mtvec_q          <= MTVEC_RESET;
            mepc_q           <= '0;
            mcause_q         <= '0;
            busy_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
`ifdef RIP_MSCRATCH_EN
            mscratch_q       <= '0;
`endif
        end else begin
            redirect_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (trap_valid) begin
                        mepc_q   <= {trap_pc[31:2], 2'b00};
                        mcause_q <= trap_cause;
                        busy_q   <= 1'b1;
                        state_q  <= StTrapSave;
                    end else if (mret_valid) begin
                        busy_q           <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= mepc_q;
                        state_q          <= StMretJump;
                    end else if (csr_we) begin
                        case (csr_addr)
                            AddrMtvec:    mtvec_q    <= {csr_new[31:2], 2'b00};
                            AddrMepc:     mepc_q     <= {csr_new[31:2], 2'b00};
                            AddrMcause:   mcause_q   <= cause_new;
`ifdef RIP_MSCRATCH_EN
                            AddrMscratch: mscratch_q <= csr_new;
`endif
                            default:      ;
                        endcase
                    end
                end
                StTrapSave: begin
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= mtvec_q;
                    state_q          <= StTrapJump;
                end
                StTrapJump, StMretJump: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy           = busy_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_rip_trap_unit.sv
// Self-checking bench for rip_trap_unit: directed vector table, hand-built trap/MRET/reset
// sequences and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps

module tb_rip_trap_unit;

    localparam logic [31:0] MtvecReset = 32'h100;
`ifdef RIP_MSCRATCH_EN
    localparam bit HasScratch = 1'b1;
`else
    localparam bit HasScratch = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret_valid;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    rip_trap_unit #(
        .MTVEC_RESET(MtvecReset),
        .CAUSE_W    (32)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .csr_op        (csr_op),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .csr_illegal   (csr_illegal),
        .trap_valid    (trap_valid),
        .trap_cause    (trap_cause),
        .trap_pc       (trap_pc),
        .mret_valid    (mret_valid),
        .busy          (busy),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural CSR values plus a queue of the outputs
    // expected in each upcoming busy cycle.
    typedef struct {
        bit          busy;
        bit          rv;
        logic [31:0] pc;
    } exp_t;

    exp_t        m_q[$];
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch, m_last_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mtvec    = MtvecReset;
        m_mepc     = 0;
        m_mcause   = 0;
        m_mscratch = 0;
        m_last_pc  = 0;
        m_q.delete();
    endtask

    task automatic m_read(input logic [11:0] a, output bit hit, output logic [31:0] v);
        hit = 1;
        v   = 0;
        if (a == 12'h305) v = m_mtvec;
        else if (a == 12'h341) v = m_mepc;
        else if (a == 12'h342) v = m_mcause;
        else if (a == 12'h340 && HasScratch) v = m_mscratch;
        else hit = 0;
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input logic tv, input logic [31:0] cause, input logic [31:0] pc,
                         input logic mv);
        csr_op     = op;
        csr_addr   = addr;
        csr_wdata  = wd;
        trap_valid = tv;
        trap_cause = cause;
        trap_pc    = pc;
        mret_valid = mv;
    endtask

    task automatic idle();
        drive(2'b00, 12'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Check the current cycle against the model, advance the model across the edge,
    // and return 1ns after that edge.
    task automatic cycle();
        exp_t        cur;
        bit          hit;
        logic [31:0] v, nv;
        #2;
        if (m_q.size() != 0) cur = m_q[0];
        else begin
            cur.busy = 0; cur.rv = 0; cur.pc = 0;
        end
        if (cur.rv) m_last_pc = cur.pc;
        check("busy", {31'b0, busy}, {31'b0, cur.busy});
        check("redirect_valid", {31'b0, redirect_valid}, {31'b0, cur.rv});
        check("redirect_pc", redirect_pc, m_last_pc);
        m_read(csr_addr, hit, v);
        if (m_q.size() == 0) begin
            check("csr_rdata", csr_rdata, (csr_op != 0 && hit) ? v : 32'h0);
            check("csr_illegal", {31'b0, csr_illegal}, {31'b0, (csr_op != 0 && !hit)});
        end
        if (m_q.size() != 0) begin
            void'(m_q.pop_front());
        end else if (trap_valid) begin
            m_mepc   = trap_pc & ~32'h3;
            m_mcause = trap_cause;
            m_q.push_back('{busy: 1, rv: 0, pc: 32'h0});
            m_q.push_back('{busy: 1, rv: 1, pc: m_mtvec});
        end else if (mret_valid) begin
            m_q.push_back('{busy: 1, rv: 1, pc: m_mepc});
        end else if (csr_op != 0 && hit) begin
            case (csr_op)
                2'b01:   nv = csr_wdata;
                2'b10:   nv = v | csr_wdata;
                default: nv = v & ~csr_wdata;
            endcase
            if (csr_addr == 12'h305) m_mtvec = nv & ~32'h3;
            else if (csr_addr == 12'h341) m_mepc = nv & ~32'h3;
            else if (csr_addr == 12'h342) m_mcause = nv;
            else m_mscratch = nv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input bit b, input bit rv, input logic [31:0] pc);
        check({name, ".busy"}, {31'b0, busy}, {31'b0, b});
        check({name, ".redirect_valid"}, {31'b0, redirect_valid}, {31'b0, rv});
        if (rv) check({name, ".redirect_pc"}, redirect_pc, pc);
    endtask

    task automatic read_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
        drive(2'b10, a, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        check(name, csr_rdata, exp);
        cycle();
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        ill;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{"rst_mtvec",    2'b10, 12'h305, 32'h0,         32'h100,  1'b0};
        vecs[1]  = '{"rst_mepc",     2'b10, 12'h341, 32'h0,         32'h0,    1'b0};
        vecs[2]  = '{"rst_mcause",   2'b10, 12'h342, 32'h0,         32'h0,    1'b0};
        vecs[3]  = '{"csrrw_mtvec",  2'b01, 12'h305, 32'h0000_2003, 32'h100,  1'b0};
        vecs[4]  = '{"rd_mtvec",     2'b10, 12'h305, 32'h0,         32'h2000, 1'b0};
        vecs[5]  = '{"csrrs_mcause", 2'b10, 12'h342, 32'h5,         32'h0,    1'b0};
        vecs[6]  = '{"csrrc_mcause", 2'b11, 12'h342, 32'h1,         32'h5,    1'b0};
        vecs[7]  = '{"rd_mcause",    2'b10, 12'h342, 32'h0,         32'h4,    1'b0};
        vecs[8]  = '{"unimpl_7c0",   2'b01, 12'h7C0, 32'h1234,      32'h0,    1'b1};
        vecs[9]  = '{"op_none",      2'b00, 12'h305, 32'hFFFF_FFFF, 32'h0,    1'b0};
        vecs[10] = '{"rd_mtvec2",    2'b10, 12'h305, 32'h0,         32'h2000, 1'b0};
        vecs[11] = '{"mscratch_wr",  2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0,    !HasScratch};
        vecs[12] = '{"mscratch_rd",  2'b10, 12'h340, 32'h0,
                     HasScratch ? 32'hDEAD_BEEF : 32'h0, !HasScratch};

        rstn = 1'b0;
        idle();
        m_reset();
        #7;
        expect_out("in_reset", 1'b0, 1'b0, 32'h0);
        check("in_reset.redirect_pc", redirect_pc, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].addr, vecs[i].wdata, 1'b0, 32'h0, 32'h0, 1'b0);
            #1;
            check({vecs[i].name, ".rdata"}, csr_rdata, vecs[i].rdata);
            check({vecs[i].name, ".illegal"}, {31'b0, csr_illegal}, {31'b0, vecs[i].ill});
            cycle();
        end

        // Trap: two busy cycles, redirect to MTVEC in the second.
        drive(2'b00, 12'h0, 32'h0, 1'b1, 32'd11, 32'h0000_0044, 1'b0);
        cycle();
        idle();
        expect_out("trap_save", 1'b1, 1'b0, 32'h0);
        cycle();
        expect_out("trap_jump", 1'b1, 1'b1, 32'h2000);
        cycle();
        expect_out("trap_done", 1'b0, 1'b0, 32'h0);
        check("trap_done.redirect_pc_hold", redirect_pc, 32'h2000);
        read_csr("trap_mepc", 12'h341, 32'h44);
        read_csr("trap_mcause", 12'h342, 32'd11);

        drive(2'b00, 12'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        cycle();
        idle();
        expect_out("mret_jump", 1'b1, 1'b1, 32'h44);
        cycle();
        expect_out("mret_done", 1'b0, 1'b0, 32'h0);

        // All three requests together: only the trap is taken.
        drive(2'b01, 12'h305, 32'hFFF0, 1'b1, 32'd2, 32'h0000_0083, 1'b1);
        cycle();
        idle();
        expect_out("prio_save", 1'b1, 1'b0, 32'h0);
        cycle();
        expect_out("prio_jump", 1'b1, 1'b1, 32'h2000);
        cycle();
        read_csr("prio_mtvec", 12'h305, 32'h2000);
        read_csr("prio_mepc", 12'h341, 32'h80);

        // Reset during TRAP_SAVE: no pulse, CSRs back to reset values.
        drive(2'b00, 12'h0, 32'h0, 1'b1, 32'd11, 32'h0000_0124, 1'b0);
        cycle();
        idle();
        rstn = 1'b0;
        #1;
        m_reset();
        expect_out("rst_mid", 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        read_csr("rst_mid_mepc", 12'h341, 32'h0);
        read_csr("rst_mid_mtvec", 12'h305, MtvecReset);

        for (int n = 0; n < 600; n++) begin
            logic [11:0] a;
            case ($urandom_range(0, 5))
                0: a = 12'h305;
                1: a = 12'h341;
                2: a = 12'h342;
                3: a = 12'h340;
                4: a = 12'h7C0;
                default: a = 12'($urandom);
            endcase
            drive(2'($urandom), a, $urandom, ($urandom_range(0, 7) == 0), $urandom, $urandom,
                  ($urandom_range(0, 7) == 0));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rip_trap_unit.md
Name: rip_trap_unit

Overview:
- Machine-mode CSR and trap sequencer for the rip-cpu core.
- Holds MTVEC (0x305), MEPC (0x341) and MCAUSE (0x342).
- Services CSR instructions from the execute stage.
- Is the consuming end of the core's trap signalling:
  - on a trap request it saves PC and cause, then redirects fetch to MTVEC.
  - on MRET it redirects fetch back to MEPC.

Parameters:
- MTVEC_RESET, 32'h0, reset value of MTVEC; must be 4-byte aligned.
- CAUSE_W, 32, width of MCAUSE and of trap_cause.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- csr_op  in  2  00 none, 01 CSRRW, 10 CSRRS, 11 CSRRC
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1 value or zero-extended immediate
- csr_rdata  out  32  old CSR value (combinational)
- csr_illegal  out  1  access to an unimplemented CSR (combinational)
- trap_valid  in  1  trap request (ecall, illegal instruction)
- trap_cause  in  CAUSE_W  cause code (2 illegal instruction, 11 ecall)
- trap_pc  in  32  PC of the faulting instruction
- mret_valid  in  1  MRET retiring
- busy  out  1  sequencer not idle; upstream must stall
- redirect_valid  out  1  one-cycle pulse: fetch must jump
- redirect_pc  out  32  jump target; valid while redirect_valid is high

Behaviour:
- Reset (async, rstn low):
  - MTVEC = MTVEC_RESET; MEPC = 0; MCAUSE = 0.
  - State = IDLE.
  - busy, redirect_valid = 0; redirect_pc = 0.
- States: IDLE, TRAP_SAVE, TRAP_JUMP, MRET_JUMP.
- Requests are sampled only in IDLE. In any other state all inputs are ignored, and the requester holds them.
- Priority when several requests arrive in the same IDLE cycle: trap_valid > mret_valid > csr_op.
  - A lower-priority request is dropped, not queued.
- Trap path:
  - IDLE + trap_valid -> TRAP_SAVE. At that edge: MEPC <= {trap_pc[31:2], 2'b00}, MCAUSE <= trap_cause.
  - TRAP_SAVE -> TRAP_JUMP unconditionally.
  - TRAP_JUMP: redirect_valid = 1, redirect_pc = MTVEC, then -> IDLE.
  - Latency: trap_valid at edge N gives the redirect pulse in cycle N+2.
  - busy is high in TRAP_SAVE and TRAP_JUMP.
- MRET path:
  - IDLE + mret_valid -> MRET_JUMP.
  - MRET_JUMP: redirect_valid = 1, redirect_pc = MEPC, then -> IDLE.
  - Latency: 1 cycle. busy is high in MRET_JUMP.
- CSR access, IDLE only, no trap_valid or mret_valid in the same cycle:
  - csr_rdata = current value of the addressed CSR, same cycle; 0 when csr_op = 00 or the address is unimplemented.
  - New value at the next edge:
    - CSRRW: new = wdata.
    - CSRRS: new = old | wdata.
    - CSRRC: new = old & ~wdata.
  - MTVEC and MEPC writes force bits [1:0] to 0. MCAUSE is written in full.
  - Unimplemented address with csr_op != 00: csr_illegal = 1, no state change. The pipeline then raises trap_valid with cause 2.
- Trap while in MRET_JUMP: ignored; the requester re-presents it once busy is low.
- redirect_pc holds its last value when redirect_valid = 0.
- Reset asserted mid-sequence: immediate return to IDLE, no redirect pulse, CSRs return to reset values.

Optional Feature:
- RIP_MSCRATCH_EN defined: adds MSCRATCH at 0x340.
  - 32-bit read/write, reset 0, all bits writable.
  - Same CSRRW/CSRRS/CSRRC rules as the other CSRs.
- RIP_MSCRATCH_EN undefined: 0x340 is unimplemented, so access gives csr_illegal = 1 and csr_rdata = 0.

Test Plan:
- Reset with MTVEC_RESET = 32'h100 -> csr_rdata at 0x305 = 32'h100; MEPC = 0; MCAUSE = 0; busy = 0; redirect_valid = 0.
- CSRRW 0x305 with wdata 32'h0000_2003 -> read returns 32'h0000_2000. Then CSRRS 0x342 with wdata 32'h5 -> MCAUSE = 5. Then CSRRC 0x342 with wdata 32'h1 -> MCAUSE = 4.
- With MTVEC = 32'h2000, assert trap_valid, cause 11, pc 32'h0000_0044 -> busy high for 2 cycles; redirect_valid for one cycle at N+2 with redirect_pc = 32'h2000; MEPC = 32'h44; MCAUSE = 11.
- Then mret_valid -> redirect_valid next cycle with redirect_pc = 32'h44; busy high for exactly 1 cycle.
- Same-cycle trap_valid, mret_valid and CSRRW 0x305 -> trap sequence only; MTVEC unchanged.
- CSRRW 0x7C0 -> csr_illegal = 1, csr_rdata = 0, no CSR changes. CSRRW 0x340 with wdata 32'hDEAD_BEEF -> reads back 32'hDEAD_BEEF only if RIP_MSCRATCH_EN is defined, otherwise csr_illegal = 1.
- Assert rstn low during TRAP_SAVE -> no redirect pulse; MEPC = 0 after reset.
